// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU controls, condition codes.
// Used by the execute-stage controller and its condition evaluator.
package y86_pkg;

    localparam int unsigned W_DATA = 64;
    localparam int unsigned W_CODE = 4;
    localparam int unsigned W_ALU  = 2;
    localparam int unsigned W_CC   = 3;

    localparam logic [W_CODE-1:0] I_HALT   = 4'h0;
    localparam logic [W_CODE-1:0] I_NOP    = 4'h1;
    localparam logic [W_CODE-1:0] I_RRMOVQ = 4'h2;
    localparam logic [W_CODE-1:0] I_IRMOVQ = 4'h3;
    localparam logic [W_CODE-1:0] I_RMMOVQ = 4'h4;
    localparam logic [W_CODE-1:0] I_MRMOVQ = 4'h5;
    localparam logic [W_CODE-1:0] I_OPQ    = 4'h6;
    localparam logic [W_CODE-1:0] I_JXX    = 4'h7;
    localparam logic [W_CODE-1:0] I_CALL   = 4'h8;
    localparam logic [W_CODE-1:0] I_RET    = 4'h9;
    localparam logic [W_CODE-1:0] I_PUSHQ  = 4'hA;
    localparam logic [W_CODE-1:0] I_POPQ   = 4'hB;

    localparam logic [W_ALU-1:0] ALU_ADD = 2'b00;
    localparam logic [W_ALU-1:0] ALU_SUB = 2'b01;
    localparam logic [W_ALU-1:0] ALU_AND = 2'b10;
    localparam logic [W_ALU-1:0] ALU_XOR = 2'b11;

    localparam logic [W_CODE-1:0] C_ALWAYS = 4'h0;
    localparam logic [W_CODE-1:0] C_LE     = 4'h1;
    localparam logic [W_CODE-1:0] C_L      = 4'h2;
    localparam logic [W_CODE-1:0] C_E      = 4'h3;
    localparam logic [W_CODE-1:0] C_NE     = 4'h4;
    localparam logic [W_CODE-1:0] C_GE     = 4'h5;
    localparam logic [W_CODE-1:0] C_G      = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    // cmovXX and jXX are the only instructions that produce a condition
    function automatic logic is_cond_op(input logic [W_CODE-1:0] icode);
        return (icode == I_RRMOVQ) || (icode == I_JXX);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_cond_eval.sv
// Combinational Y86 condition evaluation from {ZF,SF,OF} and ifun.
// Kept standalone so a branch-prediction checker can reuse it.
module cond_eval
    import y86_pkg::*;
(
    input  logic [W_CC-1:0]   i_cc,
    input  logic [W_CODE-1:0] i_ifun,
    output logic              o_cnd
);

    logic w_zf;
    logic w_sf;
    logic w_of;

    assign w_zf = i_cc[2];
    assign w_sf = i_cc[1];
    assign w_of = i_cc[0];

    always_comb begin
        o_cnd = 1'b0;
        case (i_ifun)
            C_ALWAYS: o_cnd = 1'b1;
            C_LE:     o_cnd = (w_sf ^ w_of) | w_zf;
            C_L:      o_cnd = w_sf ^ w_of;
            C_E:      o_cnd = w_zf;
            C_NE:     o_cnd = !w_zf;
            C_GE:     o_cnd = !(w_sf ^ w_of);
            C_G:      o_cnd = !(w_sf ^ w_of) && !w_zf;
            default:  o_cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Y86-64 execute-stage controller: ALU operand/control select, valE/cnd
// register and condition codes. `EXEC_STAT_EN adds a registered err output.
module alu_exec_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned     STACK_STEP = 8,
    parameter logic [W_CC-1:0] CC_RESET   = 3'b100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_CODE-1:0] icode,
    input  logic [W_CODE-1:0] ifun,
    input  logic [W_DATA-1:0] valA,
    input  logic [W_DATA-1:0] valB,
    input  logic [W_DATA-1:0] valC,
    input  logic              cc_inhibit,
    input  logic              flush,
    output logic [W_ALU-1:0]  alu_ctrl,
    output logic [W_DATA-1:0] alu_a,
    output logic [W_DATA-1:0] alu_b,
    input  logic [W_DATA-1:0] alu_c,
    input  logic              alu_of,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_DATA-1:0] valE,
    output logic              cnd,
`ifdef EXEC_STAT_EN
    output logic              err,
`endif
    output logic [W_CC-1:0]   cc
);

    localparam logic [W_DATA-1:0] STEP_POS = W_DATA'(STACK_STEP);
    localparam logic [W_DATA-1:0] STEP_NEG = W_DATA'(0) - STEP_POS;

    logic              r_out_valid;
    logic [W_DATA-1:0] r_vale;
    logic              r_cnd;
    cc_t               r_cc;

    logic [W_DATA-1:0] w_alu_a_src;
    logic [W_DATA-1:0] w_alu_b_src;
    logic [W_ALU-1:0]  w_ctrl;
    logic              w_accept;
    logic              w_cnd_raw;
    logic              w_cnd;
    logic              w_err;
    logic              w_cc_we;

    // Operand select in aluA/aluB terms; the ALU sees them swapped below
    always_comb begin
        w_alu_a_src = '0;
        w_alu_b_src = '0;
        w_ctrl      = ALU_ADD;
        case (icode)
            I_OPQ: begin
                w_alu_a_src = valA;
                w_alu_b_src = valB;
                w_ctrl      = ifun[1:0];
            end
            I_RRMOVQ: w_alu_a_src = valA;
            I_IRMOVQ: w_alu_a_src = valC;
            I_RMMOVQ, I_MRMOVQ: begin
                w_alu_a_src = valC;
                w_alu_b_src = valB;
            end
            I_CALL, I_PUSHQ: begin
                w_alu_a_src = STEP_NEG;
                w_alu_b_src = valB;
            end
            I_RET, I_POPQ: begin
                w_alu_a_src = STEP_POS;
                w_alu_b_src = valB;
            end
            default: ;
        endcase
    end

    assign alu_a    = w_alu_b_src;
    assign alu_b    = w_alu_a_src;
    assign alu_ctrl = w_ctrl;

    cond_eval u_cond_eval (
        .i_cc   (r_cc),
        .i_ifun (ifun),
        .o_cnd  (w_cnd_raw)
    );

`ifdef EXEC_STAT_EN
    assign w_err = ((icode == I_OPQ) && (ifun > 4'h3))
                 || (is_cond_op(icode) && (ifun > C_G))
                 || (icode > I_POPQ);
`else
    assign w_err = 1'b0;
`endif

    assign in_ready = !flush && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_cnd    = is_cond_op(icode) && w_cnd_raw;
    assign w_cc_we  = w_accept && (icode == I_OPQ) && !cc_inhibit && !w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_vale      <= '0;
            r_cnd       <= 1'b0;
            r_cc        <= cc_t'(CC_RESET);
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_vale      <= alu_c;
                r_cnd       <= w_cnd;
            end else if (flush || out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_cc_we) begin
                r_cc.zf <= (alu_c == '0);
                r_cc.sf <= alu_c[W_DATA-1];
                r_cc.of <= alu_of;
            end
        end
    end

`ifdef EXEC_STAT_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_err;
        end
    end

    assign err = r_err;
`endif

    assign out_valid = r_out_valid;
    assign valE      = r_vale;
    assign cnd       = r_cnd;
    assign cc        = r_cc;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: behavioural ALU, reference model,
// and a scoreboard of expected valE/cnd compared at each output transfer.
module tb_alu_exec_ctrl;

    typedef struct {
        logic [63:0] vale;
        logic        cnd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        cc_inhibit;
    logic        flush;
    logic [1:0]  alu_ctrl;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_c;
    logic        alu_of;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic        cnd;
    logic [2:0]  cc;
`ifdef EXEC_STAT_EN
    logic        err;
`endif

    exp_t        sb_q[$];
    logic [2:0]  m_cc;
    int          n_checks;
    int          n_pass;
    int          n_acc;

    alu_exec_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .icode      (icode),
        .ifun       (ifun),
        .valA       (valA),
        .valB       (valB),
        .valC       (valC),
        .cc_inhibit (cc_inhibit),
        .flush      (flush),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_of     (alu_of),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .valE       (valE),
        .cnd        (cnd),
`ifdef EXEC_STAT_EN
        .err        (err),
`endif
        .cc         (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: C = A op B
    always_comb begin
        alu_c  = '0;
        alu_of = 1'b0;
        case (alu_ctrl)
            2'b00: begin
                alu_c  = alu_a + alu_b;
                alu_of = (alu_a[63] == alu_b[63]) && (alu_c[63] != alu_a[63]);
            end
            2'b01: begin
                alu_c  = alu_a - alu_b;
                alu_of = (alu_a[63] != alu_b[63]) && (alu_c[63] != alu_a[63]);
            end
            2'b10: alu_c = alu_a & alu_b;
            default: alu_c = alu_a ^ alu_b;
        endcase
    end

    function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        case (ic)
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h6: begin
                case (fn[1:0])
                    2'b00: return b + a;
                    2'b01: return b - a;
                    2'b10: return b & a;
                    default: return b ^ a;
                endcase
            end
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                     input logic [2:0] f);
        logic zf, sf, of;
        zf = f[2];
        sf = f[1];
        of = f[0];
        if (ic != 4'h2 && ic != 4'h7) return 1'b0;
        case (fn)
            4'd0: return 1'b1;
            4'd1: return (sf ^ of) | zf;
            4'd2: return sf ^ of;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !(sf ^ of);
            4'd6: return !(sf ^ of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: score an output transfer, record an accept, then advance
    task automatic tick(output logic acc);
        exp_t        e;
        logic [63:0] r;
        logic        ofv;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_underflow: unexpected output valE=%h", valE);
            end else begin
                e = sb_q.pop_front();
                if (valE !== e.vale || cnd !== e.cnd)
                    $display("FAIL sb_result: got valE=%h cnd=%b, want valE=%h cnd=%b",
                             valE, cnd, e.vale, e.cnd);
                else
                    n_pass++;
            end
        end
        if (acc) begin
            n_acc++;
            e.vale = ref_vale(icode, ifun, valA, valB, valC);
            e.cnd  = ref_cnd(icode, ifun, m_cc);
            sb_q.push_back(e);
            if (icode == 4'h6 && !cc_inhibit) begin
                r = e.vale;
                case (ifun[1:0])
                    2'b00: ofv = (valB[63] == valA[63]) && (r[63] != valB[63]);
                    2'b01: ofv = (valB[63] != valA[63]) && (r[63] != valB[63]);
                    default: ofv = 1'b0;
                endcase
                m_cc = {r == 64'd0, r[63], ofv};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic acc;
        acc      = 1'b0;
        icode    = ic;
        ifun     = fn;
        valA     = a;
        valB     = b;
        valC     = c;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(acc);
            if (acc) break;
        end
        n_checks++;
        if (!acc) $display("FAIL send_timeout: accepted=%b, want 1 (icode=%h)", acc, ic);
        else      n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) tick(acc);
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        in_valid   = 1'b0;
        icode      = 4'h0;
        ifun       = 4'h0;
        valA       = '0;
        valB       = '0;
        valC       = '0;
        cc_inhibit = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        m_cc       = 3'b100;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || valE !== 64'd0 || cnd !== 1'b0 || cc !== 3'b100)
            $display("FAIL reset_state: got ov=%b valE=%h cnd=%b cc=%b, want 0/0/0/100",
                     out_valid, valE, cnd, cc);
        else
            n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sub_eq;
        icode = 4'h6;
        ifun  = 4'h1;
        valA  = 64'd5;
        valB  = 64'd5;
        #1;
        n_checks++;
        if (alu_ctrl !== 2'b01) $display("FAIL sub_ctrl: got %b, want 01", alu_ctrl);
        else                    n_pass++;
        send(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        send(4'h7, 4'h3, 64'd0, 64'd0, 64'h40);
        idle(2);
        n_checks++;
        if (cc !== 3'b100) $display("FAIL sub_cc: got %b, want 100", cc);
        else               n_pass++;
    endtask

    task automatic test_add_ovf;
        send(4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0);
        send(4'h7, 4'h2, 64'd0, 64'd0, 64'h80);
        idle(2);
        n_checks++;
        if (cc !== 3'b011) $display("FAIL add_cc: got %b, want 011", cc);
        else               n_pass++;
    endtask

    task automatic test_stack;
        send(4'hA, 4'h0, 64'h1, 64'h100, 64'd0);
        send(4'hB, 4'h0, 64'h2, 64'hF8, 64'd0);
        send(4'h8, 4'h0, 64'd0, 64'h200, 64'h999);
        send(4'h9, 4'h0, 64'd0, 64'h1F8, 64'd0);
        idle(2);
        n_checks++;
        if (cc !== 3'b011) $display("FAIL stack_cc: got %b, want 011", cc);
        else               n_pass++;
    endtask

    task automatic test_backpressure;
        logic acc;
        int   acc0;
        out_ready = 1'b0;
        send(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234);
        icode    = 4'h4;
        ifun     = 4'h0;
        valA     = 64'hDEAD;
        valB     = 64'h20;
        valC     = 64'h10;
        in_valid = 1'b1;
        acc0     = n_acc;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || valE !== 64'h1234 || out_valid !== 1'b1)
                $display("FAIL bp_hold: got rdy=%b ov=%b valE=%h, want 0/1/1234",
                         in_ready, out_valid, valE);
            else
                n_pass++;
            tick(acc);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(acc);
            if (acc) break;
        end
        in_valid = 1'b0;
        idle(3);
        n_checks++;
        if (n_acc - acc0 !== 1) $display("FAIL bp_accepts: got %0d, want 1", n_acc - acc0);
        else                    n_pass++;
    endtask

    task automatic test_flush;
        logic acc;
        out_ready = 1'b0;
        send(4'h3, 4'h0, 64'd0, 64'd0, 64'h55);
        icode    = 4'h6;
        ifun     = 4'h0;
        valA     = 64'd1;
        valB     = 64'd1;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b, want 0", in_ready);
        else                   n_pass++;
        tick(acc);
        n_checks++;
        if (out_valid !== 1'b0 || cc !== 3'b011 || acc !== 1'b0)
            $display("FAIL flush_state: got ov=%b cc=%b acc=%b, want 0/011/0",
                     out_valid, cc, acc);
        else
            n_pass++;
        n_checks++;
        if (sb_q.size() !== 1) $display("FAIL flush_pending: got %0d, want 1", sb_q.size());
        else                   n_pass++;
        sb_q.delete();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(2);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL flush_idle: got ov=%b, want 0", out_valid);
        else                    n_pass++;
    endtask

    task automatic test_cc_inhibit;
        cc_inhibit = 1'b1;
        send(4'h6, 4'h3, 64'd7, 64'd7, 64'd0);
        cc_inhibit = 1'b0;
        idle(2);
        n_checks++;
        if (cc !== 3'b011) $display("FAIL inhibit_cc: got %b, want 011", cc);
        else               n_pass++;
    endtask

    task automatic test_back_to_back;
        send(4'h2, 4'h0, 64'hABC, 64'd0, 64'd0);
        send(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
        send(4'hC, 4'h0, 64'h5, 64'h6, 64'h7);
        send(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
        send(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
        send(4'h6, 4'h1, 64'd1, 64'd0, 64'd0);
        send(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        send(4'h2, 4'h6, 64'h77, 64'd0, 64'd0);
        send(4'h5, 4'h0, 64'd0, 64'h1000, 64'h18);
        send(4'h6, 4'h2, 64'hF0F0, 64'h0FF0, 64'd0);
        send(4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
        idle(2);
        n_checks++;
        if (cc !== 3'b000) $display("FAIL b2b_cc: got %b, want 000", cc);
        else               n_pass++;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send(4'h3, 4'h0, 64'd0, 64'd0, 64'h77);
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || valE !== 64'd0 || cnd !== 1'b0 || cc !== 3'b100)
            $display("FAIL reset_mid: got ov=%b valE=%h cnd=%b cc=%b, want 0/0/0/100",
                     out_valid, valE, cnd, cc);
        else
            n_pass++;
        sb_q.delete();
        m_cc = 3'b100;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(4'h6, 4'h0, 64'd2, 64'd3, 64'd0);
        idle(3);
        n_checks++;
        if (sb_q.size() !== 0) $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
        else                   n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_acc    = 0;
        test_reset;
        test_sub_eq;
        test_add_ovf;
        test_stack;
        test_backpressure;
        test_flush;
        test_cc_inhibit;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
